// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq: command sequencer for a W-bit up/down counter.
// Queues {op, arg} commands in a small FIFO and replays each one as registered counter
// control pulses: clear (1 cycle), load (1 cycle) or count up/down for arg steps
// (arg == 0 means 2^W steps). Consecutive commands run back to back with no idle cycle.
// It also keeps a saturating count of overflow events, which a clear command resets.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   cmd_valid_i/ready_o   command handshake; ready = FIFO not full
//   cmd_op_i, cmd_arg_i   00 clear, 01 load arg, 10 up arg steps, 11 down arg steps
//   overflow_i            overflow/underflow flag returned by the counter
//   clear_o, en_o, load_o, down_o, d_o   registered counter controls
//   busy_o                a command is executing or queued
//   done_o                one-cycle pulse after a command's last control cycle
//   wrap_cnt_o            saturating overflow-event count
module counter_cmd_seq #(
   parameter int unsigned W          = 4,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned WRAP_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [W-1:0]      cmd_arg_i,
   input  logic              overflow_i,
   output logic              clear_o,
   output logic              en_o,
   output logic              load_o,
   output logic              down_o,
   output logic [W-1:0]      d_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [WRAP_W-1:0] wrap_cnt_o
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [W:0] StepOne  = {{W{1'b0}}, 1'b1};
   localparam logic [W:0] StepFull = {1'b1, {W{1'b0}}};

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   // Command FIFO
   logic [W+1:0]    fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            full, empty, push, pop;
   logic [1:0]      head_op;
   logic [W-1:0]    head_arg;

   assign full        = (count_q == CntW'(FIFO_DEPTH));
   assign empty       = (count_q == '0);
   assign cmd_ready_o = !full;
   assign push        = cmd_valid_i && !full;
   assign {head_op, head_arg} = fifo_mem[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {cmd_op_i, cmd_arg_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Sequencer
   state_e            state_q, state_d;
   logic [W:0]        steps_q, steps_d;   // en cycles left, including the current one
   logic              clear_q, clear_d, load_q, load_d, en_q, en_d, down_q, down_d;
   logic              done_q, done_d;
   logic [W-1:0]      d_q, d_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic              last_en;

   // Current cycle is the final en cycle of a count command.
   assign last_en = (state_q == StRun) && (steps_q == StepOne);
   // A new command may start on any edge that ends the previous command's last cycle.
   assign pop     = !empty && ((state_q == StIdle) || last_en);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         steps_q <= '0;
      end else begin
         state_q <= state_d;
         steps_q <= steps_d;
      end
   end

   always_comb begin
      state_d = state_q;
      steps_d = steps_q;
      if (pop) begin
         if (head_op[1]) begin
            state_d = StRun;
            steps_d = (head_arg == '0) ? StepFull : {1'b0, head_arg};
         end else begin
            state_d = StIdle;
         end
      end else if (state_q == StRun) begin
         steps_d = steps_q - StepOne;
         if (last_en) state_d = StIdle;
      end
   end

   always_comb begin
      clear_d = pop && (head_op == 2'b00);
      load_d  = pop && (head_op == 2'b01);
      en_d    = (pop && head_op[1]) || ((state_q == StRun) && !last_en);
      down_d  = pop ? (head_op == 2'b11) : ((state_q == StRun) && !last_en && down_q);
      d_d     = load_d ? head_arg : d_q;
      done_d  = clear_q || load_q || last_en;
      if (clear_d) begin
         wrap_d = '0;
      end else if (overflow_i && (wrap_q != {WRAP_W{1'b1}})) begin
         wrap_d = wrap_q + WRAP_W'(1);
      end else begin
         wrap_d = wrap_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clear_q <= 1'b0;
         load_q  <= 1'b0;
         en_q    <= 1'b0;
         down_q  <= 1'b0;
         done_q  <= 1'b0;
         d_q     <= '0;
         wrap_q  <= '0;
      end else begin
         clear_q <= clear_d;
         load_q  <= load_d;
         en_q    <= en_d;
         down_q  <= down_d;
         done_q  <= done_d;
         d_q     <= d_d;
         wrap_q  <= wrap_d;
      end
   end

   assign clear_o    = clear_q;
   assign load_o     = load_q;
   assign en_o       = en_q;
   assign down_o     = down_q;
   assign done_o     = done_q;
   assign d_o        = d_q;
   assign wrap_cnt_o = wrap_q;
   assign busy_o     = (state_q == StRun) || !empty || clear_q || load_q;

endmodule

// File: tb/tb_counter_cmd_seq.sv
module tb_counter_cmd_seq;

   localparam int unsigned W          = 4;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned WRAP_W     = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid, cmd_ready;
   logic [1:0]        cmd_op;
   logic [W-1:0]      cmd_arg;
   logic              overflow;
   logic              clear, en, load, down, busy, done;
   logic [W-1:0]      d;
   logic [WRAP_W-1:0] wrap_cnt;

   counter_cmd_seq #(
      .W(W), .FIFO_DEPTH(FIFO_DEPTH), .WRAP_W(WRAP_W)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg),
      .overflow_i(overflow),
      .clear_o(clear), .en_o(en), .load_o(load), .down_o(down), .d_o(d),
      .busy_o(busy), .done_o(done), .wrap_cnt_o(wrap_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: accepted commands wait in a queue; a dispatched command is expanded
   // into a list of per-cycle control words that are then played out one per cycle.
   typedef struct packed {logic clr; logic ld; logic en; logic dn;} ctl_t;

   logic [5:0]   m_q[$];
   ctl_t         m_script[$];
   ctl_t         m_cur;
   logic [W-1:0] m_d;
   logic         m_done;
   int           m_wrap;

   task automatic model_reset();
      m_q.delete();
      m_script.delete();
      m_cur  = '0;
      m_d    = '0;
      m_done = 1'b0;
      m_wrap = 0;
   endtask

   task automatic model_step();
      logic [5:0] c;
      bit         rdy;
      bit         is_clr;
      int         steps;
      rdy    = m_q.size() < FIFO_DEPTH;
      m_done = (m_cur.clr || m_cur.ld || m_cur.en) && (m_script.size() == 0);
      is_clr = 0;
      if (m_script.size() == 0 && m_q.size() > 0) begin
         c = m_q.pop_front();
         case (c[5:4])
            2'd0: begin
               m_script.push_back(ctl_t'(4'b1000));
               is_clr = 1;
            end
            2'd1: begin
               m_script.push_back(ctl_t'(4'b0100));
               m_d = c[3:0];
            end
            default: begin
               steps = (c[3:0] == 4'd0) ? 16 : int'(c[3:0]);
               for (int i = 0; i < steps; i++) m_script.push_back(ctl_t'({3'b001, c[4]}));
            end
         endcase
      end
      m_cur = (m_script.size() > 0) ? m_script.pop_front() : ctl_t'(4'b0000);
      if (is_clr) m_wrap = 0;
      else if (overflow && m_wrap < 255) m_wrap++;
      if (cmd_valid && rdy) m_q.push_back({cmd_op, cmd_arg});
   endtask

   task automatic compare_all();
      check("clear", clear, m_cur.clr);
      check("load", load, m_cur.ld);
      check("en", en, m_cur.en);
      check("down", down, m_cur.dn);
      check("d", d, m_d);
      check("done", done, m_done);
      check("busy", busy, (m_cur.clr || m_cur.ld || m_cur.en) || (m_q.size() > 0));
      check("ready", cmd_ready, m_q.size() < FIFO_DEPTH);
      check("wrap_cnt", wrap_cnt, m_wrap);
   endtask

   always @(posedge clk) begin
      if (rst) model_reset();
      else     model_step();
      #1;
      compare_all();
   end

   // Called at a negedge; returns at the negedge following acceptance with valid still high,
   // so consecutive calls present commands without a bubble.
   task automatic push_cmd(input logic [1:0] op, input logic [W-1:0] arg);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("push_ready", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain", busy, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_arg   = '0;
      overflow  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single clear
      push_cmd(2'd0, 4'd0);
      wait_idle();

      // Load then count up 3, back to back
      push_cmd(2'd1, 4'hA);
      push_cmd(2'd2, 4'd3);
      wait_idle();

      // Count down 16 steps with one overflow event
      push_cmd(2'd3, 4'd0);
      repeat (4) @(negedge clk);
      overflow = 1'b1;
      @(negedge clk);
      overflow = 1'b0;
      wait_idle();
      check("wrap_one", wrap_cnt, 8'd1);

      // Valid held while the engine runs; FIFO fills and back-pressures
      push_cmd(2'd2, 4'd5);
      push_cmd(2'd2, 4'd1);
      push_cmd(2'd3, 4'd2);
      push_cmd(2'd1, 4'd7);
      wait_idle();

      // Asynchronous reset mid-command with two commands queued
      push_cmd(2'd2, 4'd9);
      push_cmd(2'd0, 4'd0);
      push_cmd(2'd1, 4'd3);
      #2;
      rst = 1'b1;
      #1;
      check("arst_en", en, 1'b0);
      check("arst_clear", clear, 1'b0);
      check("arst_load", load, 1'b0);
      check("arst_down", down, 1'b0);
      check("arst_d", d, '0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_wrap", wrap_cnt, '0);
      @(negedge clk);
      rst = 1'b0;
      check("post_rst_ready", cmd_ready, 1'b1);
      check("post_rst_busy", busy, 1'b0);
      repeat (20) @(negedge clk);

      // Overflow saturation, then clear while overflow stays high
      overflow = 1'b1;
      repeat (300) @(negedge clk);
      check("wrap_sat", wrap_cnt, 8'd255);
      push_cmd(2'd0, 4'd0);
      wait_idle();
      overflow = 1'b0;
      @(negedge clk);

      // Randomized traffic; payload held while valid is stalled
      for (int i = 0; i < 2000; i++) begin
         overflow = ($urandom_range(0, 9) == 0);
         if (!(cmd_valid && !cmd_ready)) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_arg   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      overflow  = 1'b0;
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
